// File: rtl/host_descriptor_arbiter.sv
// Round-robin arbiter sharing the host descriptor FIFO between the HCP and network writers.
// Define HDA_RELEASE_TIMEOUT_EN to add a release timeout on the WAIT states.
module host_descriptor_arbiter #(
  parameter int                 FIFO_AW    = 8,
  parameter logic [FIFO_AW-1:0] AFULL_TH   = 8'd250,
  parameter logic [15:0]        RELEASE_TO = 16'd1024
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [47:0]        iv_tsntag_hcp,
  input  logic [8:0]         iv_bufid_hcp,
  input  logic               i_inverse_map_lookup_flag_hcp,
  input  logic               i_descriptor_wr_hcp,
  output logic               o_descriptor_ack_hcp,
  input  logic [47:0]        iv_tsntag_network,
  input  logic [8:0]         iv_bufid_network,
  input  logic               i_inverse_map_lookup_flag_network,
  input  logic               i_descriptor_wr_network,
  output logic               o_descriptor_ack_network,
  input  logic [FIFO_AW-1:0] iv_fifo_usedw,
  output logic [23:0]        ov_fifo_wdata,
  output logic               o_fifo_wr,
  output logic [15:0]        ov_hcp_cnt,
  output logic [15:0]        ov_network_cnt,
  output logic               o_release_err
);

  typedef enum logic [1:0] {
    IDLE_S     = 2'd0,
    WAIT_HCP_S = 2'd1,
    WAIT_NET_S = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_hcp;
  logic        w_grant_hcp;
  logic        w_grant_net;
  logic        w_timeout;
  logic [15:0] r_hcp_cnt;
  logic [15:0] r_network_cnt;
  logic [23:0] w_desc_hcp;
  logic [23:0] w_desc_net;
  logic        w_unused_tag_bits;

  assign w_desc_hcp = {i_inverse_map_lookup_flag_hcp, iv_tsntag_hcp[44:31], iv_bufid_hcp};
  assign w_desc_net = {i_inverse_map_lookup_flag_network, iv_tsntag_network[44:31], iv_bufid_network};

  // Only tag bits 44:31 travel with the descriptor.
  assign w_unused_tag_bits = ^{iv_tsntag_hcp[47:45], iv_tsntag_hcp[30:0],
                               iv_tsntag_network[47:45], iv_tsntag_network[30:0]};

`ifdef HDA_RELEASE_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_release_err;
  logic        w_in_wait;

  assign w_in_wait = (r_state == WAIT_HCP_S) || (r_state == WAIT_NET_S);
  assign w_timeout = w_in_wait && (r_to_cnt == RELEASE_TO - 16'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt      <= 16'd0;
      r_release_err <= 1'b0;
    end else begin
      if (w_in_wait && (w_state_next != IDLE_S)) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end else begin
        r_to_cnt <= 16'd0;
      end
      if (w_timeout) begin
        r_release_err <= 1'b1;
      end
    end
  end

  assign o_release_err = r_release_err;
`else
  assign w_timeout     = 1'b0;
  assign o_release_err = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_grant_hcp  = 1'b0;
    w_grant_net  = 1'b0;
    case (r_state)
      IDLE_S: begin
        if (iv_fifo_usedw < AFULL_TH) begin
          // On a tie the port that did not win last time gets the slot.
          if (i_descriptor_wr_hcp && i_descriptor_wr_network) begin
            if (r_last_hcp) begin
              w_grant_net = 1'b1;
            end else begin
              w_grant_hcp = 1'b1;
            end
          end else if (i_descriptor_wr_hcp) begin
            w_grant_hcp = 1'b1;
          end else if (i_descriptor_wr_network) begin
            w_grant_net = 1'b1;
          end
        end
        if (w_grant_hcp) begin
          w_state_next = WAIT_HCP_S;
        end else if (w_grant_net) begin
          w_state_next = WAIT_NET_S;
        end
      end
      WAIT_HCP_S: begin
        if (!i_descriptor_wr_hcp || w_timeout) begin
          w_state_next = IDLE_S;
        end
      end
      WAIT_NET_S: begin
        if (!i_descriptor_wr_network || w_timeout) begin
          w_state_next = IDLE_S;
        end
      end
      default: begin
        w_state_next = IDLE_S;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state                  <= IDLE_S;
      r_last_hcp               <= 1'b0;
      o_descriptor_ack_hcp     <= 1'b0;
      o_descriptor_ack_network <= 1'b0;
      o_fifo_wr                <= 1'b0;
      ov_fifo_wdata            <= 24'd0;
    end else begin
      r_state                  <= w_state_next;
      o_descriptor_ack_hcp     <= w_grant_hcp;
      o_descriptor_ack_network <= w_grant_net;
      o_fifo_wr                <= w_grant_hcp | w_grant_net;
      if (w_grant_hcp) begin
        ov_fifo_wdata <= w_desc_hcp;
        r_last_hcp    <= 1'b1;
      end else if (w_grant_net) begin
        ov_fifo_wdata <= w_desc_net;
        r_last_hcp    <= 1'b0;
      end else begin
        ov_fifo_wdata <= 24'd0;
      end
    end
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcp_cnt     <= 16'd0;
      r_network_cnt <= 16'd0;
    end else begin
      if (w_grant_hcp && (r_hcp_cnt != 16'hFFFF)) begin
        r_hcp_cnt <= r_hcp_cnt + 16'd1;
      end
      if (w_grant_net && (r_network_cnt != 16'hFFFF)) begin
        r_network_cnt <= r_network_cnt + 16'd1;
      end
    end
  end

  assign ov_hcp_cnt     = r_hcp_cnt;
  assign ov_network_cnt = r_network_cnt;

endmodule

// File: tb/tb_host_descriptor_arbiter.sv
// Scoreboard bench for host_descriptor_arbiter: directed requests, expected grants queued in order.
`timescale 1ns/1ps
module tb_host_descriptor_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] tag_h, tag_n;
  logic [8:0]  buf_h, buf_n;
  logic        flag_h, flag_n;
  logic        wr_h, wr_n;
  logic        ack_h, ack_n;
  logic [7:0]  usedw;
  logic [23:0] wdata;
  logic        fwr;
  logic [15:0] cnt_h, cnt_n;
  logic        err;

  always #5 clk = ~clk;

  host_descriptor_arbiter #(.RELEASE_TO(16'd16)) dut (
    .i_clk                             (clk),
    .i_rst_n                           (rst_n),
    .iv_tsntag_hcp                     (tag_h),
    .iv_bufid_hcp                      (buf_h),
    .i_inverse_map_lookup_flag_hcp     (flag_h),
    .i_descriptor_wr_hcp               (wr_h),
    .o_descriptor_ack_hcp              (ack_h),
    .iv_tsntag_network                 (tag_n),
    .iv_bufid_network                  (buf_n),
    .i_inverse_map_lookup_flag_network (flag_n),
    .i_descriptor_wr_network           (wr_n),
    .o_descriptor_ack_network          (ack_n),
    .iv_fifo_usedw                     (usedw),
    .ov_fifo_wdata                     (wdata),
    .o_fifo_wr                         (fwr),
    .ov_hcp_cnt                        (cnt_h),
    .ov_network_cnt                    (cnt_n),
    .o_release_err                     (err)
  );

  typedef struct {
    bit          is_hcp;
    logic [23:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   acks_h = 0;
  int   acks_n = 0;
  bit   auto_h = 0, auto_n = 0, stick_h = 0, stick_n = 0;
  int   pend_h = 0, pend_n = 0;

  localparam logic [23:0] HCP_DESC = 24'hA46805; // {1'b1, 14'h1234, 9'h005}
  localparam logic [23:0] NET_DESC = 24'h5579A3; // {1'b0, 14'h2ABC, 9'h1A3}

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(bit is_hcp);
    exp_t e;
    e.is_hcp = is_hcp;
    e.data   = is_hcp ? HCP_DESC : NET_DESC;
    sb.push_back(e);
  endtask

  // Monitor: every grant seen on the outputs must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ack_h) acks_h++;
        if (ack_n) acks_n++;
        if (ack_h || ack_n || fwr) begin
          check("fifo_wr_vs_ack", {31'd0, fwr}, {31'd0, ack_h | ack_n});
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant: got ack_hcp=%0b ack_net=%0b expected no grant", ack_h, ack_n);
          end else begin
            e = sb.pop_front();
            check("grant_port", {30'd0, ack_h, ack_n}, e.is_hcp ? 32'd2 : 32'd1);
            check("fifo_wdata", {8'd0, wdata}, {8'd0, e.data});
          end
        end
      end
    end
  end

  // Requesters: raise wr while work is pending, drop it at the negedge of the ack cycle.
  initial forever begin
    @(negedge clk);
    if (auto_h) begin
      if (ack_h) begin
        pend_h--;
        if (!stick_h) wr_h = 1'b0;
      end else if (pend_h > 0 && !wr_h) begin
        wr_h = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_n) begin
      if (ack_n) begin
        pend_n--;
        if (!stick_n) wr_n = 1'b0;
      end else if (pend_n > 0 && !wr_n) begin
        wr_n = 1'b1;
      end
    end
  end

  task automatic wait_drain(string name, int max_cycles);
    int n;
    n = 0;
    while ((sb.size() != 0 || pend_h > 0 || pend_n > 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || pend_h > 0 || pend_n > 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d grants outstanding expected 0", name, sb.size());
      sb.delete();
      pend_h = 0;
      pend_n = 0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int n;
    rst_n  = 1'b0;
    wr_h   = 1'b0;
    wr_n   = 1'b0;
    usedw  = 8'd0;
    tag_h  = 48'hFFFF_FFFF_FFFF;
    tag_n  = 48'hFFFF_FFFF_FFFF;
    tag_h[44:31] = 14'h1234;
    tag_n[44:31] = 14'h2ABC;
    buf_h  = 9'h005;
    buf_n  = 9'h1A3;
    flag_h = 1'b1;
    flag_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack_hcp", {31'd0, ack_h}, 32'd0);
    check("rst_ack_net", {31'd0, ack_n}, 32'd0);
    check("rst_fifo_wr", {31'd0, fwr}, 32'd0);
    check("rst_wdata", {8'd0, wdata}, 32'd0);
    check("rst_cnt_hcp", {16'd0, cnt_h}, 32'd0);
    check("rst_cnt_net", {16'd0, cnt_n}, 32'd0);
    check("rst_release_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    // HCP alone, wr held 4 cycles: exactly one grant.
    push(1'b1);
    @(negedge clk);
    wr_h = 1'b1;
    repeat (4) @(negedge clk);
    wr_h = 1'b0;
    repeat (4) @(negedge clk);
    check("hcp_only_drained", sb.size(), 32'd0);
    check("hcp_only_acks", acks_h, 32'd1);
    check("hcp_only_cnt", {16'd0, cnt_h}, 32'd1);

    // Both continuous after reset: strict alternation starting with HCP.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(1'b1);
      push(1'b0);
    end
    pend_h = 3;
    pend_n = 3;
    auto_h = 1'b1;
    auto_n = 1'b1;
    wait_drain("alternate", 60);
    check("alt_cnt_hcp", {16'd0, cnt_h}, 32'd3);
    check("alt_cnt_net", {16'd0, cnt_n}, 32'd3);

    // Almost-full backpressure at 250, released at 249.
    usedw = 8'd250;
    base = acks_n;
    push(1'b0);
    pend_n = 1;
    repeat (10) @(negedge clk);
    check("bp_no_ack", acks_n - base, 32'd0);
    check("bp_wr_held", {31'd0, wr_n}, 32'd1);
    usedw = 8'd249;
    @(negedge clk);
    check("bp_ack_next_cycle", {31'd0, ack_n}, 32'd1);
    wait_drain("backpressure", 20);
    usedw = 8'd0;

    // Saturation of the network counter.
    @(negedge clk);
    force dut.r_network_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_network_cnt;
    @(negedge clk);
    check("sat_preload", {16'd0, cnt_n}, 32'h0000FFFE);
    push(1'b0);
    pend_n = 1;
    wait_drain("sat1", 20);
    check("sat_first", {16'd0, cnt_n}, 32'h0000FFFF);
    push(1'b0);
    pend_n = 1;
    wait_drain("sat2", 20);
    check("sat_hold", {16'd0, cnt_n}, 32'h0000FFFF);

    // Reset while the network grant is held in its WAIT state.
    stick_n = 1'b1;
    push(1'b0);
    pend_n = 1;
    base = acks_n;
    n = 0;
    while (acks_n == base && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_net_granted", acks_n - base, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ack_net", {31'd0, ack_n}, 32'd0);
    check("midrst_fifo_wr", {31'd0, fwr}, 32'd0);
    check("midrst_cnt_hcp", {16'd0, cnt_h}, 32'd0);
    check("midrst_cnt_net", {16'd0, cnt_n}, 32'd0);
    stick_n = 1'b0;
    pend_n  = 1;
    pend_h  = 1;
    sb.delete();
    push(1'b1);
    push(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("post_reset", 30);
    check("postrst_cnt_hcp", {16'd0, cnt_h}, 32'd1);
    check("postrst_cnt_net", {16'd0, cnt_n}, 32'd1);

    // HCP never releases: the timeout build re-grants it, the default build waits.
    stick_h = 1'b1;
    base = acks_h;
    push(1'b1);
`ifdef HDA_RELEASE_TIMEOUT_EN
    push(1'b1);
`endif
    pend_h = 1;
    repeat (25) @(negedge clk);
`ifdef HDA_RELEASE_TIMEOUT_EN
    check("stuck_acks", acks_h - base, 32'd2);
    check("stuck_release_err", {31'd0, err}, 32'd1);
`else
    check("stuck_acks", acks_h - base, 32'd1);
    check("stuck_release_err", {31'd0, err}, 32'd0);
`endif
    check("stuck_drained", sb.size(), 32'd0);
    stick_h = 1'b0;
    auto_h  = 1'b0;
    pend_h  = 0;
    wr_h    = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
